hamming_encoder_stage: RTL

- Downstream consumer of the 4-bit counter data source: accepts 4-bit data words over valid/ready and emits Hamming(7,4) codewords over valid/ready.
- Includes a 2-entry output buffer and a deterministic single-bit error injector, so the downstream decoder/corrector sees a known mix of clean and corrupted codewords.
- Sits between the data counter and the Hamming decoder in the error-detection/correction demo datapath.

---
 rtl/hamming_pkg.sv | 31 +++
 rtl/sync_fifo2.sv | 48 ++++
 rtl/hamming_encoder_stage.sv | 75 +++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, bit positions and encoder function.
// Used by the encoder stage and by the decoder bench.
package hamming_pkg;

  typedef logic [3:0] data_t;
  typedef logic [6:0] code_t;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P4_IDX = 3;

  typedef struct packed {
    code_t      code;
    logic       err;
    logic [2:0] pos;
  } enc_entry_t;

  function automatic code_t hamming74_encode(data_t d);
    code_t c;
    c         = '0;
    c[2]      = d[0];
    c[4]      = d[1];
    c[5]      = d[2];
    c[6]      = d[3];
    c[P1_IDX] = d[0] ^ d[1] ^ d[3];
    c[P2_IDX] = d[0] ^ d[2] ^ d[3];
    c[P4_IDX] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry first-word-fall-through buffer, W-bit payload.
// Ports: clk, reset(active-low sync), push/wdata, pop/rdata, full, valid.
module sync_fifo2 #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         valid
);

  logic [1:0]   count;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'(DEPTH));
  assign valid   = (count != 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Head reads as zero when empty.
  assign rdata   = valid ? mem0 : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      if (do_pop && count == 2'd2)
        mem0 <= mem1;
      if (do_push) begin
        if (count == 2'd0 || (count == 2'd1 && do_pop))
          mem0 <= wdata;
        else
          mem1 <= wdata;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/hamming_encoder_stage.sv
// Hamming(7,4) encoder with periodic single-bit error injection.
// Ports: in_valid/in_data/in_ready, inject_en, out_valid/out_code/out_ready, out_err_*.
module hamming_encoder_stage
  import hamming_pkg::*;
#(
  parameter int INJECT_PERIOD = 4,
  parameter int DEPTH         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       inject_en,
  output logic       out_valid,
  output logic [6:0] out_code,
  input  logic       out_ready,
  output logic       out_err_injected,
  output logic [2:0] out_err_pos
);

  localparam logic [3:0] CNT_LAST = 4'(INJECT_PERIOD - 1);

  logic [3:0] cnt;
  logic [2:0] ptr;
  logic       full;
  logic       accept;
  logic       fire;
  code_t      mask;
  enc_entry_t wr;
  enc_entry_t rd;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign fire     = inject_en && (cnt == CNT_LAST);

  always_comb begin
    mask = '0;
    if (fire)
      mask = 7'd1 << (ptr - 3'd1);
    wr.code = hamming74_encode(in_data) ^ mask;
    wr.err  = fire;
    wr.pos  = fire ? ptr : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 4'd0;
      ptr <= 3'd1;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
      if (fire)
        ptr <= (ptr == 3'd7) ? 3'd1 : ptr + 3'd1;
    end
  end

  sync_fifo2 #(
    .W     ($bits(enc_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (wr),
    .pop   (out_ready),
    .rdata (rd),
    .full  (full),
    .valid (out_valid)
  );

  assign out_code         = rd.code;
  assign out_err_injected = rd.err;
  assign out_err_pos      = rd.pos;

endmodule
